alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshakes on input and output.
//  Keeps the existing 4-bit opcode map and adds full status flags, add-with-carry
//  from a stored carry flag, an iterative shift-add multiply and an error flag for
//  undefined opcodes. Sits between the decode stage and the register writeback.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=4)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand/opcode presented
//  in_ready   out  1      block can accept; transfer when in_valid && in_ready
//  A, B       in   WIDTH  operands
//  opcode     in   4      operation select
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//  result     out  WIDTH  operation result
//  carry_out  out  1      carry/borrow/shifted-out bit
//  zero       out  1      result == 0
//  negative   out  1      result[WIDTH-1]
//  overflow   out  1      signed overflow (arithmetic ops only, else 0)
//  err        out  1      undefined opcode
//  busy       out  1      multiply in progress
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, stored carry flag (cf) 0; mid-multiply reset aborts, no output.
//  Ops: 0000 ADD A+B | 0001 SUB A-B (carry=borrow, A<B) | 0010 INC A+1 | 0100 DEC A-1
//   0101 ADC A+B+cf | 1000 AND | 1001 OR | 1010 NOT ~A | 1100 XOR
//   1110 SL A<<1 (carry=A[MSB]) | 0111 SR A>>1 logical (carry=A[0])
//   0011 MUL low WIDTH bits of A*B unsigned, carry=1 iff high WIDTH bits nonzero
//   0110 NOP: accepted, produces no output, flags and cf unchanged
//   1011,1101,1111: result=0, err=1, other flags 0, out_valid asserted
//  INC carry=1 iff A all-ones; DEC carry=1 iff A==0. Logic ops carry=0.
//  overflow: two's-complement overflow for ADD/SUB/ADC/INC/DEC; 0 otherwise.
//  cf <= carry_out on each produced ADD/SUB/ADC/INC/DEC/SL/SR/MUL result; else held.
//  FSM IDLE -> (accept MUL) -> MUL -> (WIDTH iterations done) -> IDLE, writing output reg.
//  in_ready = (state==IDLE) && (!out_valid || out_ready); low throughout MUL.
//  Single-cycle op accepted at edge k: out_valid=1 after edge k+1 (latency 1); back-to-back
//   throughput 1/cycle when out_ready held high.
//  MUL accepted at edge k: busy=1 from edge k+1 for WIDTH cycles; out_valid after edge k+WIDTH+1.
//  Output regs hold stable while out_valid && !out_ready; out_valid drops after handshake
//   unless a new result loads the same edge.
//  ADC uses cf value at acceptance edge, including cf written by the result loaded that edge.
// TESTING
//  ADD A=FF B=01 -> result 00, carry 1, zero 1, overflow 0; cf=1 then ADC 00+00 -> 01.
//  SUB A=10 B=20 -> F0, carry 1, negative 1; ADD 7F+01 -> 80, overflow 1, negative 1.
//  MUL 0D*0B -> 8F carry 0, out_valid exactly 9 cycles after accept; MUL 10*10 -> 00 carry 1.
//  Hold out_ready=0 for 5 cycles after ADD -> in_ready=0, result/flags stable; release -> next op accepted.
//  Deassert rst_n 3 cycles into MUL -> all outputs 0, in_ready=1 after release, no stale result.
//  opcode 1111 -> err 1, result 00; opcode 0110 -> no out_valid, cf unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops pass through one operand register (_p0) and land in the
// output register on the following edge; MUL runs an iterative shift-add
// datapath (_p1) for WIDTH cycles before loading the output register.
// The stored carry flag (cf) feeds ADC and is updated as results are produced.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             err,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_INC = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DEC = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_NOP = 4'b0110;
  localparam logic [3:0] OP_SR  = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_SL  = 4'b1110;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Signed range limits of a WIDTH-bit two's-complement value, held in WIDTH+1 bits.
  localparam logic signed [WIDTH:0] S_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] S_MIN = ~S_MAX;
  localparam logic signed [WIDTH:0] S_ONE = (WIDTH+1)'(1);
  localparam logic        [WIDTH:0] U_ONE = (WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 cf;

  logic                 vld_p0;
  logic [3:0]           op_p0;
  logic [WIDTH-1:0]     a_p0;
  logic [WIDTH-1:0]     b_p0;

  logic [2*WIDTH-1:0]   acc_p1;
  logic [2*WIDTH-1:0]   mcand_p1;
  logic [WIDTH-1:0]     mplier_p1;

  logic                 out_free;
  logic                 fire;
  logic                 fire_mul;
  logic                 p0_load;
  logic                 mul_load;
  logic [WIDTH+2:0]     alu_p0;

  logic [WIDTH-1:0]     nxt_result;
  logic                 nxt_carry;
  logic                 nxt_zero;
  logic                 nxt_negative;
  logic                 nxt_overflow;
  logic                 nxt_err;
  logic                 nxt_cf_wr;

  // Sign-extend an operand by one bit so sums keep their true signed value.
  function automatic logic signed [WIDTH:0] sx(input logic [WIDTH-1:0] x);
    return $signed({x[WIDTH-1], x});
  endfunction

  // Two's-complement overflow: the exact signed sum left the WIDTH-bit range.
  function automatic logic sat_ovf(input logic signed [WIDTH:0] s);
    return (s > S_MAX) || (s < S_MIN);
  endfunction

  // Ops whose carry is latched into cf when their result is produced.
  function automatic logic cf_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) ||
           (op == OP_INC) || (op == OP_DEC) || (op == OP_SL)  || (op == OP_SR);
  endfunction

  // Single-cycle ALU: returns {err, overflow, carry, result}.
  function automatic logic [WIDTH+2:0] alu_compute(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH:0]        usum;
    logic signed [WIDTH:0] ssum;
    logic [WIDTH-1:0]      res;
    logic                  c;
    logic                  v;
    logic                  e;
    usum = '0;
    ssum = '0;
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    e    = 1'b0;
    case (op)
      OP_ADD: begin
        usum = {1'b0, a} + {1'b0, b};
        ssum = sx(a) + sx(b);
        res  = usum[WIDTH-1:0];
        c    = usum[WIDTH];
        v    = sat_ovf(ssum);
      end
      OP_SUB: begin
        usum = {1'b0, a} - {1'b0, b};
        ssum = sx(a) - sx(b);
        res  = usum[WIDTH-1:0];
        c    = (a < b);
        v    = sat_ovf(ssum);
      end
      OP_ADC: begin
        usum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        ssum = sx(a) + sx(b) + $signed({{WIDTH{1'b0}}, cin});
        res  = usum[WIDTH-1:0];
        c    = usum[WIDTH];
        v    = sat_ovf(ssum);
      end
      OP_INC: begin
        usum = {1'b0, a} + U_ONE;
        ssum = sx(a) + S_ONE;
        res  = usum[WIDTH-1:0];
        c    = &a;
        v    = sat_ovf(ssum);
      end
      OP_DEC: begin
        usum = {1'b0, a} - U_ONE;
        ssum = sx(a) - S_ONE;
        res  = usum[WIDTH-1:0];
        c    = (a == '0);
        v    = sat_ovf(ssum);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOT: res = ~a;
      OP_XOR: res = a ^ b;
      OP_SL: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
      end
      OP_SR: begin
        res = {1'b0, a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_MUL, OP_NOP: res = '0;
      default: e = 1'b1;
    endcase
    return {e, v, c, res};
  endfunction

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == S_IDLE) && out_free;
  assign fire     = in_valid && in_ready;
  assign fire_mul = fire && (opcode == OP_MUL);
  assign p0_load  = vld_p0 && out_free && (op_p0 != OP_NOP);
  assign mul_load = (state == S_DONE) && out_free;
  assign alu_p0   = alu_compute(op_p0, a_p0, b_p0, cf);

  // Select the value the output register loads: multiplier product or ALU result.
  always_comb begin
    nxt_result   = alu_p0[WIDTH-1:0];
    nxt_carry    = alu_p0[WIDTH];
    nxt_overflow = alu_p0[WIDTH+1];
    nxt_err      = alu_p0[WIDTH+2];
    nxt_cf_wr    = p0_load && cf_op(op_p0);
    if (state == S_DONE) begin
      nxt_result   = acc_p1[WIDTH-1:0];
      nxt_carry    = |acc_p1[2*WIDTH-1:WIDTH];
      nxt_overflow = 1'b0;
      nxt_err      = 1'b0;
      nxt_cf_wr    = mul_load;
    end
    nxt_zero     = !nxt_err && (nxt_result == '0);
    nxt_negative = nxt_result[WIDTH-1];
  end

  // Operand stage p0 and the shift-add multiplier datapath p1 (data only, no reset).
  always_ff @(posedge clk) begin
    // p0: operand capture at acceptance
    if (fire) begin
      op_p0 <= opcode;
      a_p0  <= A;
      b_p0  <= B;
    end
    // p1: one shift-add step per cycle while the FSM is in MUL
    if (fire_mul) begin
      acc_p1    <= '0;
      mcand_p1  <= {{WIDTH{1'b0}}, A};
      mplier_p1 <= B;
    end else if (state == S_MUL) begin
      if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  // Control FSM, stored carry flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      vld_p0    <= 1'b0;
      cf        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (fire && !fire_mul) vld_p0 <= 1'b1;
      else if (out_free)     vld_p0 <= 1'b0;

      case (state)
        S_IDLE: begin
          if (fire_mul) begin
            state <= S_MUL;
            cnt   <= '0;
          end
        end
        S_MUL: begin
          busy <= 1'b1;
          cnt  <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= S_DONE;
        end
        S_DONE: begin
          if (out_free) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (p0_load || mul_load) begin
        out_valid <= 1'b1;
        result    <= nxt_result;
        carry_out <= nxt_carry;
        zero      <= nxt_zero;
        negative  <= nxt_negative;
        overflow  <= nxt_overflow;
        err       <= nxt_err;
        if (nxt_cf_wr) cf <= nxt_carry;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
